// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared access-size encodings, strobe width and store entry layout
package store_buffer_pkg;
  localparam int STRB_W = 4;
  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_H  = 3'b001,
    OP_HU = 3'b010,
    OP_B  = 3'b011,
    OP_BU = 3'b100
  } op_e;
  // Word address is kept beside the record in the queue because its width follows AW.
  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic [31:0]       data;
  } entry_t;
endpackage

// File: rtl/store_buffer_sb_fifo.sv
// sb_fifo: DEPTH-entry circular store queue with associative word-address match.
// Ports: push/pop with entry in, head entry out, occupancy count, match on match_addr.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                push_addr,
  input  entry_t                       push_entry,
  input  logic [AW-1:0]                match_addr,
  output logic [AW-1:0]                head_addr,
  output entry_t                       head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         match
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]    wp, rp;
  logic [AW-1:0]    addr_q [DEPTH];
  entry_t           ent_q  [DEPTH];
  logic [DEPTH-1:0] vld;
  // Pop clears before push sets, so a full-buffer push onto the popped slot stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[rp] <= 1'b0;
        rp      <= rp + PW'(1);
      end
      if (push) begin
        addr_q[wp] <= push_addr;
        ent_q[wp]  <= push_entry;
        vld[wp]    <= 1'b1;
        wp         <= wp + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && addr_q[i] == match_addr) match = 1'b1;
  end
  assign head_addr  = addr_q[rp];
  assign head_entry = ent_q[rp];
endmodule

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store buffer draining to a single memory port, with load forwarding stalls.
// Ports: req_* MEM access in, exc_commit mask, stall/adel/ades status, ld_valid/ld_data load result,
// mem_* shared memory port (loads take priority over draining).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic          exc_commit,
  output logic          stall,
  output logic          adel,
  output logic          ades,
  output logic          ld_valid,
  output logic [31:0]   ld_data,
  output logic          mem_en,
  output logic [3:0]    mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata
);
  localparam int CW = $clog2(DEPTH+1);
  function automatic logic [3:0] strobe(logic [2:0] op, logic [1:0] a);
    return op == OP_W ? 4'b1111 :
           (op == OP_H || op == OP_HU) ? (a[1] ? 4'b1100 : 4'b0011) :
           4'b0001 << a;
  endfunction
  function automatic logic [31:0] replicate(logic [2:0] op, logic [31:0] d);
    return op == OP_W ? d : (op == OP_H || op == OP_HU) ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
  function automatic logic [31:0] extend(logic [2:0] op, logic [1:0] a, logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? d[31:16] : d[15:0];
    b = d[{a, 3'b000} +: 8];
    return op == OP_H  ? {{16{h[15]}}, h} :
           op == OP_HU ? {16'b0, h} :
           op == OP_B  ? {{24{b[7]}}, b} :
           op == OP_BU ? {24'b0, b} : d;
  endfunction
  logic [AW-1:0] word, head_addr;
  entry_t        head_entry;
  logic [CW-1:0] count;
  logic          mis, live, is_load, is_store, hazard, load_port, drain, pop, push;
  logic          ld_q;
  logic [2:0]    ld_op_q;
  logic [1:0]    ld_lane_q;
  assign word = {req_addr[AW-1:2], 2'b00};
  assign mis  = ((req_op == OP_H || req_op == OP_HU) && req_addr[0]) ||
                (req_op == OP_W && req_addr[1:0] != 2'b00);
  assign adel = req_valid & ~req_write & mis;
  assign ades = req_valid & req_write & mis;
  assign live      = req_valid & ~exc_commit & ~rst & ~mis;
  assign is_load   = live & ~req_write;
  assign is_store  = live & req_write;
  // A load whose word is still buffered must wait; draining continues so it can clear.
  assign load_port = is_load & ~hazard;
  assign drain     = count != '0 & ~load_port & ~rst;
  assign pop       = drain & mem_ready;
  assign stall     = is_load ? (hazard | ~mem_ready) : is_store & count == CW'(DEPTH) & ~pop;
  assign push      = is_store & ~stall;
  assign mem_en    = load_port | drain;
  assign mem_wen   = drain ? head_entry.strb : 4'b0000;
  assign mem_addr  = load_port ? word : head_addr;
  assign mem_wdata = head_entry.data;
  assign ld_valid  = ld_q & ~rst;
  assign ld_data   = ld_valid ? extend(ld_op_q, ld_lane_q, mem_rdata) : 32'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q <= 1'b0;
    end else begin
      ld_q <= load_port & mem_ready;
    end
    ld_op_q   <= req_op;
    ld_lane_q <= req_addr[1:0];
  end
  sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_addr  (word),
    .push_entry ('{strb: strobe(req_op, req_addr[1:0]), data: replicate(req_op, req_wdata)}),
    .match_addr (word),
    .head_addr  (head_addr),
    .head_entry (head_entry),
    .count      (count),
    .match      (hazard)
  );
endmodule
